ps2_key_decoder: RTL and testbench

- Receives the raw PS/2 keyboard clock/data pair and turns it into make-code events for `game_state_machine`.
- Synchronizes and glitch-filters the PS/2 lines, deserializes 11-bit frames and tracks the `E0`/`F0` prefixes.
- Publishes `keycode` plus a one-cycle `new_key_strobe` per key press; break (release) codes are consumed silently.
- Sits directly upstream of the game state machine, in the `clk` domain.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 38 +++
 rtl/ps2_key_decoder.sv | 154 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  // Make codes consumed by game_state_machine
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;

  // Observation bundle for the frame FSM and decoder flags
  typedef struct packed {
    frame_state_t state;
    logic [2:0]   bit_cnt;
    logic         par;
    logic         ext;
    logic         brk;
  } ps2_dbg_t;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus saturating glitch counter for one raw PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Output flips on the FILTER_LEN-th consecutive disagreeing sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      line_filt <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_raw};
      if (sync_q[1] != line_filt) begin
        if (cnt_q == CNT_MAX) begin
          line_filt <= sync_q[1];
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: filtered lines, 11-bit frame FSM, E0/F0 prefix decode.
// Optional odd-parity checking is enabled with `define PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_extended,
  output logic       new_key_strobe,
  output logic       frame_error,
  output ps2_dbg_t   dbg
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);

  logic clk_f, data_f, clk_q, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst_n(rst_n), .line_raw(ps2_clk), .line_filt(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst_n(rst_n), .line_raw(ps2_data), .line_filt(data_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q <= 1'b1;
      fall  <= 1'b0;
    end else begin
      clk_q <= clk_f;
      fall  <= clk_q & ~clk_f;
    end
  end

  frame_state_t state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift_q, shift_n;
  logic          par_q, par_n;
  logic [WW-1:0] wd_cnt, wd_n;
  logic          byte_done, err;
  logic          ext_q, brk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      wd_cnt  <= wd_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_q;
    par_n     = par_q;
    wd_n      = wd_cnt;
    byte_done = 1'b0;
    err       = 1'b0;

    // Watchdog counts cycles since the last fall; a fall always wins
    if (state == ST_IDLE || fall) begin
      wd_n = '0;
    end else if (wd_cnt == WD_MAX) begin
      wd_n    = '0;
      err     = 1'b1;
      state_n = ST_IDLE;
    end else begin
      wd_n = wd_cnt + 1'b1;
    end

    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!data_f) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          shift_n   = {data_f, shift_q[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n   = data_f;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
`ifdef PS2_PARITY_CHECK_EN
          if (data_f && (^{shift_q, par_q})) byte_done = 1'b1;
          else                               err       = 1'b1;
`else
          if (data_f) byte_done = 1'b1;
          else        err       = 1'b1;
`endif
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Byte decoder: prefixes arm flags, break codes are swallowed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keycode        <= '0;
      key_extended   <= 1'b0;
      new_key_strobe <= 1'b0;
      frame_error    <= 1'b0;
      ext_q          <= 1'b0;
      brk_q          <= 1'b0;
    end else begin
      new_key_strobe <= 1'b0;
      frame_error    <= err;
      if (err) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_done) begin
        if (shift_q == PS2_EXT_PREFIX) begin
          ext_q <= 1'b1;
        end else if (shift_q == PS2_BREAK_PREFIX) begin
          brk_q <= 1'b1;
        end else if (brk_q) begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end else begin
          keycode        <= shift_q;
          key_extended   <= ext_q;
          new_key_strobe <= 1'b1;
          ext_q          <= 1'b0;
        end
      end
    end
  end

  assign dbg = '{state: state, bit_cnt: bit_cnt, par: par_q, ext: ext_q, brk: brk_q};

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, strobe scoreboard.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_extended, new_key_strobe, frame_error;
  ps2_dbg_t   dbg;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .key_extended(key_extended),
    .new_key_strobe(new_key_strobe), .frame_error(frame_error), .dbg(dbg)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected {key_extended, keycode} per strobe
  logic [8:0] exp_q[$];
  int strobe_cnt = 0, ferr_cnt = 0, viol = 0;
  int last_strobe_cyc = 0, last_ferr_cyc = 0, last_fall_cyc = 0;
  logic prev_strobe = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (new_key_strobe) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      check("strobe_key", {23'd0, key_extended, keycode}, {23'd0, e});
    end
    if (frame_error) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
    end
    if (new_key_strobe && prev_strobe) viol++;
    if (frame_error && prev_err)       viol++;
    if (new_key_strobe && frame_error) viol++;
    prev_strobe = new_key_strobe;
    prev_err    = frame_error;
  end

  // Driver tasks
  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b = 1'b1,
                            input logic bad_par = 1'b0, input int nbits = 11);
    logic [10:0] bits;
    bits = {stop_b, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    if (nbits == 11) begin
      @(negedge clk) ps2_data = 1'b1;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (30) @(negedge clk);
  endtask

  int s0, f0, d;

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_keycode", keycode, 8'h00);
    check("rst_ext", key_extended, 1'b0);
    check("rst_strobe", new_key_strobe, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_state", dbg.state, ST_IDLE);
    rst_n = 1'b1;
    settle();

    // Plain make code plus two typematic repeats
    s0 = strobe_cnt; f0 = ferr_cnt;
    exp_q.push_back({1'b0, 8'h1B});
    send_frame(8'h1B);
    settle();
    check("make_strobes", strobe_cnt - s0, 1);
    check("make_latency", last_strobe_cyc - last_fall_cyc, FL + 4);
    check("make_keycode", keycode, 8'h1B);
    check("make_ext", key_extended, 1'b0);
    exp_q.push_back({1'b0, 8'h1B});
    exp_q.push_back({1'b0, 8'h1B});
    send_frame(8'h1B);
    send_frame(8'h1B);
    settle();
    check("typematic_strobes", strobe_cnt - s0, 3);

    // Extended make E0 75
    s0 = strobe_cnt;
    send_frame(PS2_EXT_PREFIX);
    settle();
    check("e0_no_strobe", strobe_cnt - s0, 0);
    exp_q.push_back({1'b1, 8'h75});
    send_frame(8'h75);
    settle();
    check("ext_strobes", strobe_cnt - s0, 1);
    check("ext_keycode", keycode, 8'h75);
    check("ext_flag", key_extended, 1'b1);

    // 1B F0 1B: release swallowed, flags clear afterwards
    s0 = strobe_cnt;
    exp_q.push_back({1'b0, 8'h1B});
    send_frame(8'h1B);
    send_frame(PS2_BREAK_PREFIX);
    send_frame(8'h1B);
    settle();
    check("break_strobes", strobe_cnt - s0, 1);
    check("brk_flag_clear", dbg.brk, 1'b0);
    check("ext_flag_clear", dbg.ext, 1'b0);

    // Extended break E0 F0 75, then plain 72
    s0 = strobe_cnt;
    send_frame(PS2_EXT_PREFIX);
    send_frame(PS2_BREAK_PREFIX);
    send_frame(8'h75);
    exp_q.push_back({1'b0, 8'h72});
    send_frame(8'h72);
    settle();
    check("ext_break_strobes", strobe_cnt - s0, 1);
    check("after_ext_break_ext", key_extended, 1'b0);

    // Bad stop bit on 4D
    s0 = strobe_cnt; f0 = ferr_cnt;
    send_frame(8'h4D, 1'b0);
    settle();
    check("stop_err_count", ferr_cnt - f0, 1);
    check("stop_err_no_strobe", strobe_cnt - s0, 0);
    check("stop_err_keycode", keycode, 8'h72);
    // Error drops a pending E0
    send_frame(PS2_EXT_PREFIX);
    send_frame(8'h4D, 1'b0);
    exp_q.push_back({1'b0, 8'h75});
    send_frame(8'h75);
    settle();
    check("err_clears_ext", key_extended, 1'b0);
    check("after_err_keycode", keycode, 8'h75);

    // Timeout after 4 data bits
    s0 = strobe_cnt; f0 = ferr_cnt;
    send_frame(8'h2D, 1'b1, 1'b0, 5);
    repeat (TO / 2) @(negedge clk);
    check("no_early_timeout", ferr_cnt - f0, 0);
    repeat (TO / 2 + 50) @(negedge clk);
    check("timeout_count", ferr_cnt - f0, 1);
    d = last_ferr_cyc - last_fall_cyc;
    check("timeout_latency", (d >= TO + 10 && d <= TO + 14), 1'b1);
    check("timeout_state", dbg.state, ST_IDLE);
    ps2_data = 1'b1;
    settle();
    exp_q.push_back({1'b0, 8'h2D});
    send_frame(8'h2D);
    settle();
    check("post_timeout_keycode", keycode, 8'h2D);
    check("post_timeout_strobes", strobe_cnt - s0, 1);

    // Wrong parity on 74
    s0 = strobe_cnt; f0 = ferr_cnt;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h74, 1'b1, 1'b1);
    settle();
    check("parity_err_count", ferr_cnt - f0, 1);
    check("parity_err_no_strobe", strobe_cnt - s0, 0);
    check("parity_err_keycode", keycode, 8'h2D);
`else
    exp_q.push_back({1'b0, 8'h74});
    send_frame(8'h74, 1'b1, 1'b1);
    settle();
    check("parity_ignored_err", ferr_cnt - f0, 0);
    check("parity_ignored_strobe", strobe_cnt - s0, 1);
    check("parity_ignored_keycode", keycode, 8'h74);
`endif

    // Short ps2_clk glitches with data low must not start a frame
    s0 = strobe_cnt; f0 = ferr_cnt;
    @(negedge clk) ps2_data = 1'b0;
    repeat (H) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      repeat (FL - 3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (30) @(negedge clk);
    end
    check("glitch_state", dbg.state, ST_IDLE);
    ps2_data = 1'b1;
    settle();
    exp_q.push_back({1'b0, 8'h6B});
    send_frame(8'h6B);
    settle();
    check("glitch_no_err", ferr_cnt - f0, 0);
    check("glitch_keycode", keycode, 8'h6B);

    // Reset mid-frame
    s0 = strobe_cnt;
    send_frame(8'h76, 1'b1, 1'b0, 4);
    check("mid_frame_state", dbg.state, ST_DATA);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_keycode", keycode, 8'h00);
    check("midrst_ext", key_extended, 1'b0);
    check("midrst_state", dbg.state, ST_IDLE);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
    check("midrst_no_strobe", strobe_cnt - s0, 0);
    exp_q.push_back({1'b0, 8'h76});
    send_frame(8'h76);
    settle();
    check("post_rst_keycode", keycode, 8'h76);
    check("post_rst_strobes", strobe_cnt - s0, 1);

    // Global properties
    check("pulse_violations", viol, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
